// File: rtl/arb_pkg.sv
// Shared types for the IF/MEM memory arbiter: FSM states, grant codes and the
// byte-enable pattern used for full-word instruction reads.
package arb_pkg;

   typedef enum logic [1:0] {
      IDLE,
      INSTR,
      DATA,
      DRAIN
   } arb_state_e;

   typedef enum logic [1:0] {
      GNT_NONE,
      GNT_INSTR,
      GNT_DATA
   } arb_grant_e;

   localparam logic [3:0] BYTE_EN_ALL = 4'hF;

endpackage

// File: rtl/mem_arbiter.sv
// Single-port memory shared by instruction fetch and data access. Data wins by
// default; a streak limiter lets a waiting fetch through after MAX_DATA_STREAK data grants.
module mem_arbiter
   import arb_pkg::*;
#(
   parameter int BITSIZE         = 32,
   parameter int MAX_DATA_STREAK = 4
) (
   input  logic               clk,
   input  logic               resetn_i,
   input  logic               flush_i,
   input  logic [BITSIZE-1:0] instr_addr_i,
   input  logic               instr_read_i,
   output logic [31:0]        instr_data_o,
   output logic               instr_valid_o,
   input  logic [BITSIZE-1:0] data_addr_i,
   input  logic               data_read_i,
   input  logic               data_write_i,
   input  logic [31:0]        data_wdata_i,
   input  logic [3:0]         data_be_i,
   output logic [31:0]        data_rdata_o,
   output logic               data_valid_o,
   output logic [BITSIZE-1:0] mem_addr_o,
   output logic               mem_read_o,
   output logic               mem_write_o,
   output logic [31:0]        mem_wdata_o,
   output logic [3:0]         mem_be_o,
   input  logic [31:0]        mem_rdata_i,
   input  logic               mem_valid_i
);

   localparam int SW = (MAX_DATA_STREAK < 2) ? 1 : $clog2(MAX_DATA_STREAK + 1);
   localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DATA_STREAK);

   arb_state_e         r_state;
   logic [SW-1:0]      r_streak;
   logic [BITSIZE-1:0] r_mem_addr;
   logic               r_mem_read;
   logic               r_mem_write;
   logic [31:0]        r_mem_wdata;
   logic [3:0]         r_mem_be;

   logic       w_instr_req;
   logic       w_data_req;
   logic       w_limit;
   logic       w_instr_done;
   logic       w_data_done;
   arb_grant_e w_grant;

   // A fetch raised in the same cycle as a flush is for the wrong path.
   assign w_instr_req = instr_read_i & ~flush_i;
   assign w_data_req  = data_read_i | data_write_i;
   assign w_limit     = (MAX_DATA_STREAK > 0) && (r_streak == STREAK_MAX);

   always_comb begin
      w_grant = GNT_NONE;
      if (r_state == IDLE) begin
         if (w_data_req && !(w_instr_req && w_limit)) begin
            w_grant = GNT_DATA;
         end else if (w_instr_req) begin
            w_grant = GNT_INSTR;
         end
      end
   end

   always_ff @(posedge clk or negedge resetn_i) begin
      if (!resetn_i) begin
         r_state     <= IDLE;
         r_streak    <= '0;
         r_mem_addr  <= '0;
         r_mem_read  <= 1'b0;
         r_mem_write <= 1'b0;
         r_mem_wdata <= '0;
         r_mem_be    <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               case (w_grant)
                  GNT_DATA: begin
                     r_state     <= DATA;
                     r_mem_addr  <= data_addr_i;
                     r_mem_write <= data_write_i;
                     r_mem_read  <= ~data_write_i;
                     r_mem_wdata <= data_wdata_i;
                     r_mem_be    <= data_be_i;
                     if (!w_instr_req) begin
                        r_streak <= '0;
                     end else if (r_streak != STREAK_MAX) begin
                        r_streak <= r_streak + 1'b1;
                     end
                  end
                  GNT_INSTR: begin
                     r_state     <= INSTR;
                     r_mem_addr  <= instr_addr_i;
                     r_mem_read  <= 1'b1;
                     r_mem_write <= 1'b0;
                     r_mem_wdata <= '0;
                     r_mem_be    <= BYTE_EN_ALL;
                     r_streak    <= '0;
                  end
                  default: ;
               endcase
            end
            INSTR: begin
               if (mem_valid_i) begin
                  r_state    <= IDLE;
                  r_mem_read <= 1'b0;
               end else if (flush_i) begin
                  // Memory cannot be cancelled: keep the strobe up and swallow the reply.
                  r_state <= DRAIN;
               end
            end
            DATA, DRAIN: begin
               if (mem_valid_i) begin
                  r_state     <= IDLE;
                  r_mem_read  <= 1'b0;
                  r_mem_write <= 1'b0;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign w_instr_done = (r_state == INSTR) && mem_valid_i && !flush_i;
   assign w_data_done  = (r_state == DATA) && mem_valid_i;

   assign instr_valid_o = w_instr_done;
   assign instr_data_o  = w_instr_done ? mem_rdata_i : '0;
   assign data_valid_o  = w_data_done;
   assign data_rdata_o  = w_data_done ? mem_rdata_i : '0;

   assign mem_addr_o  = r_mem_addr;
   assign mem_read_o  = r_mem_read;
   assign mem_write_o = r_mem_write;
   assign mem_wdata_o = r_mem_wdata;
   assign mem_be_o    = r_mem_be;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed requester stimulus, a latency-
// programmable memory model, and a monitor checking every issue and response.
module tb_mem_arbiter;

   logic        clk;
   logic        resetn_i;
   logic        flush_i;
   logic [31:0] instr_addr_i;
   logic        instr_read_i;
   logic [31:0] instr_data_o;
   logic        instr_valid_o;
   logic [31:0] data_addr_i;
   logic        data_read_i;
   logic        data_write_i;
   logic [31:0] data_wdata_i;
   logic [3:0]  data_be_i;
   logic [31:0] data_rdata_o;
   logic        data_valid_o;
   logic [31:0] mem_addr_o;
   logic        mem_read_o;
   logic        mem_write_o;
   logic [31:0] mem_wdata_o;
   logic [3:0]  mem_be_o;
   logic [31:0] mem_rdata_i;
   logic        mem_valid_i;

   mem_arbiter #(.BITSIZE(32), .MAX_DATA_STREAK(4)) dut (
      .clk(clk), .resetn_i(resetn_i), .flush_i(flush_i),
      .instr_addr_i(instr_addr_i), .instr_read_i(instr_read_i),
      .instr_data_o(instr_data_o), .instr_valid_o(instr_valid_o),
      .data_addr_i(data_addr_i), .data_read_i(data_read_i),
      .data_write_i(data_write_i), .data_wdata_i(data_wdata_i),
      .data_be_i(data_be_i), .data_rdata_o(data_rdata_o),
      .data_valid_o(data_valid_o), .mem_addr_o(mem_addr_o),
      .mem_read_o(mem_read_o), .mem_write_o(mem_write_o),
      .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o),
      .mem_rdata_i(mem_rdata_i), .mem_valid_i(mem_valid_i)
   );

   typedef struct {
      logic [31:0] addr;
      logic        rd;
      logic        wr;
      logic [3:0]  be;
      logic [31:0] wd;
   } mem_exp_t;

   mem_exp_t    exp_mem[$];
   logic [31:0] exp_instr[$];
   logic [31:0] exp_data[$];

   int n_tests = 0;
   int n_fail  = 0;
   int lat     = 1;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [31:0] mem_val(input logic [31:0] a);
      if (a == 32'h100) return 32'h0050_0093;
      return a ^ 32'h5A5A_0000;
   endfunction

   task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic timeout_fail(input string name);
      n_tests++;
      n_fail++;
      $display("FAIL %s: timed out at %0t", name, $time);
   endtask

   task automatic push_mem(input logic [31:0] a, input logic rd, input logic wr,
                           input logic [3:0] be, input logic [31:0] wd);
      mem_exp_t e;
      e.addr = a; e.rd = rd; e.wr = wr; e.be = be; e.wd = wd;
      exp_mem.push_back(e);
   endtask

   task automatic do_instr(input logic [31:0] a);
      instr_addr_i = a;
      instr_read_i = 1'b1;
      for (int i = 0; i < 60; i++) begin
         @(posedge clk); #2;
         if (instr_valid_o) begin
            instr_read_i = 1'b0;
            return;
         end
      end
      instr_read_i = 1'b0;
      timeout_fail("instr_wait");
   endtask

   task automatic do_data(input logic [31:0] a, input logic wr,
                          input logic [31:0] wd, input logic [3:0] be);
      data_addr_i  = a;
      data_write_i = wr;
      data_read_i  = ~wr;
      data_wdata_i = wd;
      data_be_i    = be;
      for (int i = 0; i < 80; i++) begin
         @(posedge clk); #2;
         if (data_valid_o) begin
            data_read_i  = 1'b0;
            data_write_i = 1'b0;
            return;
         end
      end
      data_read_i  = 1'b0;
      data_write_i = 1'b0;
      timeout_fail("data_wait");
   endtask

   // Memory model: replies `lat` cycles after the first strobe cycle, one-cycle valid.
   initial begin
      int cnt;
      cnt = 0;
      mem_valid_i = 1'b0;
      mem_rdata_i = '0;
      forever begin
         @(posedge clk); #1;
         if (!resetn_i) begin
            cnt = 0; mem_valid_i = 1'b0; mem_rdata_i = '0;
         end else if (mem_valid_i) begin
            cnt = 0; mem_valid_i = 1'b0; mem_rdata_i = '0;
         end else if (mem_read_o || mem_write_o) begin
            if (cnt >= lat) begin
               mem_valid_i = 1'b1;
               mem_rdata_i = mem_write_o ? 32'h0 : mem_val(mem_addr_o);
            end else begin
               cnt++;
            end
         end else begin
            cnt = 0;
         end
      end
   end

   // Monitor: checks every memory issue and every port response against the queues.
   initial begin
      logic        prev_strobe;
      logic [31:0] cur_addr;
      mem_exp_t    e;
      prev_strobe = 1'b0;
      cur_addr    = '0;
      forever begin
         @(negedge clk);
         if (!resetn_i) begin
            prev_strobe = 1'b0;
         end else begin
            if ((mem_read_o || mem_write_o) && !prev_strobe) begin
               if (exp_mem.size() == 0) begin
                  timeout_fail("unexpected_mem_issue");
               end else begin
                  e = exp_mem.pop_front();
                  chk("mem_issue_addr_rd_wr_be", {mem_addr_o, mem_read_o, mem_write_o, mem_be_o},
                      {e.addr, e.rd, e.wr, e.be});
                  if (e.wr) chk("mem_issue_wdata", mem_wdata_o, e.wd);
               end
               cur_addr = mem_addr_o;
            end else if (mem_read_o || mem_write_o) begin
               chk("mem_addr_stable", mem_addr_o, cur_addr);
            end
            prev_strobe = mem_read_o || mem_write_o;

            if (instr_valid_o) begin
               if (exp_instr.size() == 0) timeout_fail("unexpected_instr_valid");
               else chk("instr_data", instr_data_o, exp_instr.pop_front());
            end else begin
               chk("instr_data_idle", instr_data_o, 32'h0);
            end
            if (data_valid_o) begin
               if (exp_data.size() == 0) timeout_fail("unexpected_data_valid");
               else chk("data_rdata", data_rdata_o, exp_data.pop_front());
            end else begin
               chk("data_rdata_idle", data_rdata_o, 32'h0);
            end
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int cnt;
      logic seen;
      resetn_i = 1'b0; flush_i = 1'b0;
      instr_addr_i = '0; instr_read_i = 1'b0;
      data_addr_i = '0; data_read_i = 1'b0; data_write_i = 1'b0;
      data_wdata_i = '0; data_be_i = '0;

      repeat (3) @(posedge clk);
      #2;
      chk("rst_mem_outputs", {mem_addr_o, mem_read_o, mem_write_o, mem_be_o}, 72'h0);
      chk("rst_mem_wdata", mem_wdata_o, 32'h0);
      chk("rst_valids", {instr_valid_o, data_valid_o}, 2'b00);
      chk("rst_state", dut.r_state, arb_pkg::IDLE);
      chk("rst_streak", dut.r_streak, 0);
      resetn_i = 1'b1;
      @(posedge clk); #2;

      // Single fetch, memory answers two cycles after the strobe.
      lat = 2;
      push_mem(32'h100, 1'b1, 1'b0, 4'hF, 32'h0);
      exp_instr.push_back(32'h0050_0093);
      instr_addr_i = 32'h100;
      instr_read_i = 1'b1;
      cnt = 0;
      seen = 1'b0;
      for (int i = 0; i < 30 && !seen; i++) begin
         @(posedge clk); #2;
         if (mem_read_o) cnt++;
         if (instr_valid_o) seen = 1'b1;
      end
      instr_read_i = 1'b0;
      if (!seen) timeout_fail("fetch_valid");
      chk("fetch_strobe_cycles", cnt, 3);
      repeat (2) @(posedge clk); #2;

      // Simultaneous requests: data first, then the fetch.
      lat = 1;
      push_mem(32'h1000, 1'b1, 1'b0, 4'hF, 32'h0);
      push_mem(32'h200, 1'b1, 1'b0, 4'hF, 32'h0);
      exp_data.push_back(mem_val(32'h1000));
      exp_instr.push_back(mem_val(32'h200));
      fork
         do_data(32'h1000, 1'b0, 32'h0, 4'hF);
         do_instr(32'h200);
      join
      repeat (2) @(posedge clk); #2;

      // Starvation limit: four data grants, then the waiting fetch, then data again.
      lat = 1;
      for (int k = 0; k < 4; k++) push_mem(32'h2000 + 32'(4 * k), 1'b1, 1'b0, 4'hF, 32'h0);
      push_mem(32'h500, 1'b1, 1'b0, 4'hF, 32'h0);
      push_mem(32'h2010, 1'b1, 1'b0, 4'hF, 32'h0);
      push_mem(32'h2014, 1'b1, 1'b0, 4'hF, 32'h0);
      for (int k = 0; k < 6; k++) exp_data.push_back(mem_val(32'h2000 + 32'(4 * k)));
      exp_instr.push_back(mem_val(32'h500));
      fork
         begin
            for (int k = 0; k < 6; k++) do_data(32'h2000 + 32'(4 * k), 1'b0, 32'h0, 4'hF);
         end
         begin
            do_instr(32'h500);
            chk("streak_after_instr_grant", dut.r_streak, 0);
         end
      join
      repeat (2) @(posedge clk); #2;

      // Partial write.
      lat = 1;
      push_mem(32'h1004, 1'b0, 1'b1, 4'h3, 32'hDEAD_BEEF);
      exp_data.push_back(32'h0);
      do_data(32'h1004, 1'b1, 32'hDEAD_BEEF, 4'h3);
      repeat (2) @(posedge clk); #2;

      // Flush one cycle after the fetch is issued; stale reply must be swallowed.
      lat = 3;
      push_mem(32'h300, 1'b1, 1'b0, 4'hF, 32'h0);
      push_mem(32'h400, 1'b1, 1'b0, 4'hF, 32'h0);
      exp_instr.push_back(mem_val(32'h400));
      instr_addr_i = 32'h300;
      instr_read_i = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(posedge clk); #2;
         if (mem_read_o) seen = 1'b1;
      end
      if (!seen) timeout_fail("flush_issue");
      @(posedge clk); #2;
      flush_i = 1'b1;
      instr_addr_i = 32'h400;
      @(posedge clk); #2;
      flush_i = 1'b0;
      chk("flush_enters_drain", dut.r_state, arb_pkg::DRAIN);
      do_instr(32'h400);
      repeat (2) @(posedge clk); #2;

      // Asynchronous reset in the middle of a data transaction.
      lat = 6;
      push_mem(32'h1008, 1'b1, 1'b0, 4'hF, 32'h0);
      data_addr_i = 32'h1008;
      data_read_i = 1'b1;
      data_be_i = 4'hF;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(posedge clk); #2;
         if (mem_read_o) seen = 1'b1;
      end
      if (!seen) timeout_fail("reset_txn_issue");
      repeat (2) @(posedge clk);
      #3;
      chk("pre_reset_state", dut.r_state, arb_pkg::DATA);
      resetn_i = 1'b0;
      #1;
      chk("async_rst_mem", {mem_addr_o, mem_read_o, mem_write_o, mem_be_o}, 72'h0);
      chk("async_rst_valids", {instr_valid_o, data_valid_o}, 2'b00);
      data_read_i = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      resetn_i = 1'b1;
      lat = 1;
      push_mem(32'h600, 1'b1, 1'b0, 4'hF, 32'h0);
      exp_instr.push_back(mem_val(32'h600));
      do_instr(32'h600);

      repeat (4) @(posedge clk); #2;
      chk("left_mem_expect", exp_mem.size(), 0);
      chk("left_instr_expect", exp_instr.size(), 0);
      chk("left_data_expect", exp_data.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
